// File: rtl/chacha_round_sequencer_if.sv
// -----------------------------------------------------------------------------
// chacha_round_sequencer_if
//   Bundles the control, quarter-round handshake and feed-forward signals that
//   connect the ChaCha round sequencer to the I/O shell and the QR/adder
//   datapath.
//
//   Signals
//     start      shell -> seq   begin a block (sampled only when idle)
//     abort      shell -> seq   synchronous cancel
//     busy       seq -> shell   block in progress, including the done cycle
//     done       seq -> shell   one-cycle completion pulse
//     qr_valid   seq -> QR      quarter-round request
//     qr_ready   QR -> seq      request accepted this cycle
//     qr_done    QR -> seq      result of the accepted request written back
//     qr_a..qr_d seq -> QR      state word indices for the quarter round
//     add_valid  seq -> adder   feed-forward add of word add_idx this cycle
//     add_idx    seq -> adder   feed-forward word index 0..15
//     dr_cnt     seq -> shell   completed double rounds (status)
//
//   Modports
//     master     sequencer view (drives status, QR request and add controls)
//     slave      environment view (drives start/abort and the QR handshake)
// -----------------------------------------------------------------------------
interface chacha_round_sequencer_if;
   logic       start;
   logic       abort;
   logic       busy;
   logic       done;
   logic       qr_valid;
   logic       qr_ready;
   logic       qr_done;
   logic [3:0] qr_a;
   logic [3:0] qr_b;
   logic [3:0] qr_c;
   logic [3:0] qr_d;
   logic       add_valid;
   logic [3:0] add_idx;
   logic [4:0] dr_cnt;

   modport master (
      input  start, abort, qr_ready, qr_done,
      output busy, done, qr_valid, qr_a, qr_b, qr_c, qr_d,
             add_valid, add_idx, dr_cnt
   );

   modport slave (
      output start, abort, qr_ready, qr_done,
      input  busy, done, qr_valid, qr_a, qr_b, qr_c, qr_d,
             add_valid, add_idx, dr_cnt
   );
endinterface

// File: rtl/chacha_round_sequencer.sv
// -----------------------------------------------------------------------------
// chacha_round_sequencer
//   Controller for the ChaCha block function. Drives one shared quarter-round
//   unit through the column/diagonal schedule for DOUBLE_ROUNDS double rounds,
//   then steps the feed-forward adder over all 16 state words and pulses done.
//
//   Parameters
//     DOUBLE_ROUNDS  double rounds per block (10 = ChaCha20, 4 = ChaCha8), 1..31
//
//   Ports
//     clk   rising-edge clock
//     rst   asynchronous, active-high reset
//     bus   chacha_round_sequencer_if.master (start/abort in; busy, done,
//           QR request/handshake, feed-forward add and dr_cnt)
//
//   All outputs come straight from flops; the QR indices only change when a
//   new request is loaded, so they stay stable while qr_valid waits for
//   qr_ready.
// -----------------------------------------------------------------------------
module chacha_round_sequencer #(
   parameter int DOUBLE_ROUNDS = 10
) (
   input  logic                            clk,
   input  logic                            rst,
   chacha_round_sequencer_if.master        bus
);

   localparam logic [4:0] DR_LAST = 5'(DOUBLE_ROUNDS);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT,
      S_ADD,
      S_DONE
   } state_t;

   state_t      state_q, state_d;
   logic [2:0]  step_q, step_d;
   logic [4:0]  dr_q, dr_d;
   logic [3:0]  add_q, add_d;
   logic [15:0] idx_q, idx_d;     // {a, b, c, d} of the current quarter round
   logic        busy_q, done_q, qr_valid_q, add_valid_q;

   // Quarter-round word indices for a schedule step. Steps 0..3 are the
   // columns (a, a+4, a+8, a+12); steps 4..7 are the diagonals, where the
   // b/c/d rows rotate by 1/2/3 positions within their 4-word row.
   function automatic logic [15:0] sched(input logic [2:0] s);
      logic [1:0] rb, rc, rd;
      rb = s[1:0];
      rc = s[1:0];
      rd = s[1:0];
      if (s[2]) begin
         rb = s[1:0] + 2'd1;
         rc = s[1:0] + 2'd2;
         rd = s[1:0] + 2'd3;
      end
      return {2'b00, s[1:0], 2'b01, rb, 2'b10, rc, 2'b11, rd};
   endfunction

   always_comb begin
      // NOTE: every variable gets a default before the case so no path can
      // leave one unassigned, which would otherwise infer a latch.
      state_d = state_q;
      step_d  = step_q;
      dr_d    = dr_q;
      add_d   = add_q;
      idx_d   = idx_q;

      case (state_q)
         S_IDLE: begin
            if (bus.start && !bus.abort) begin
               state_d = S_ISSUE;
               step_d  = 3'd0;
               dr_d    = 5'd0;
               idx_d   = sched(3'd0);
            end
         end

         S_ISSUE: begin
            if (bus.qr_ready) begin
               state_d = S_WAIT;
            end
         end

         // qr_done is only looked at here; the unit never reports completion
         // in the same cycle it accepts a request.
         S_WAIT: begin
            if (bus.qr_done) begin
               step_d = step_q + 3'd1;   // wraps 7 -> 0 at the double-round boundary
               if (step_q == 3'd7) begin
                  dr_d = dr_q + 5'd1;
               end
               if ((step_q == 3'd7) && ((dr_q + 5'd1) == DR_LAST)) begin
                  state_d = S_ADD;
                  add_d   = 4'd0;
               end else begin
                  state_d = S_ISSUE;
                  idx_d   = sched(step_q + 3'd1);
               end
            end
         end

         S_ADD: begin
            if (add_q == 4'd15) begin
               state_d = S_DONE;
            end else begin
               add_d = add_q + 4'd1;
            end
         end

         S_DONE: begin
            state_d = S_IDLE;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Abort outranks everything except reset and returns all state to its
      // reset values; in IDLE it has no effect beyond blocking a start.
      if (bus.abort && (state_q != S_IDLE)) begin
         state_d = S_IDLE;
         step_d  = 3'd0;
         dr_d    = 5'd0;
         add_d   = 4'd0;
         idx_d   = 16'd0;
      end
   end

   // Status strobes are decoded from the next state and registered, so each
   // one is valid for exactly the cycles its state is occupied.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         step_q      <= 3'd0;
         dr_q        <= 5'd0;
         add_q       <= 4'd0;
         idx_q       <= 16'd0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         qr_valid_q  <= 1'b0;
         add_valid_q <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments here so every flop samples the values
         // from before this edge, independent of statement order.
         state_q     <= state_d;
         step_q      <= step_d;
         dr_q        <= dr_d;
         add_q       <= add_d;
         idx_q       <= idx_d;
         busy_q      <= (state_d != S_IDLE);
         done_q      <= (state_d == S_DONE);
         qr_valid_q  <= (state_d == S_ISSUE);
         add_valid_q <= (state_d == S_ADD);
      end
   end

   assign bus.busy      = busy_q;
   assign bus.done      = done_q;
   assign bus.qr_valid  = qr_valid_q;
   assign bus.qr_a      = idx_q[15:12];
   assign bus.qr_b      = idx_q[11:8];
   assign bus.qr_c      = idx_q[7:4];
   assign bus.qr_d      = idx_q[3:0];
   assign bus.add_valid = add_valid_q;
   assign bus.add_idx   = add_q;
   assign bus.dr_cnt    = dr_q;

endmodule

// File: tb/tb_chacha_round_sequencer.sv
// -----------------------------------------------------------------------------
// tb_chacha_round_sequencer
//   Self-checking bench for chacha_round_sequencer. A ChaCha20 instance is
//   driven through nominal, stalled, start-while-busy, abort and async-reset
//   scenarios; a ChaCha8 instance checks the shorter schedule. A scoreboard
//   queues the expected QR index tuples and add indices when a start is
//   accepted and pops them as the sequencer issues them. The bench acts as the
//   QR unit: qr_done is returned in the first cycle after acceptance.
// -----------------------------------------------------------------------------
module tb_chacha_round_sequencer;

   localparam int DR  = 10;
   localparam int DR4 = 4;

   // {a, b, c, d} per schedule step
   localparam logic [15:0] SCHED [8] = '{
      16'h048C, 16'h159D, 16'h26AE, 16'h37BF,
      16'h05AF, 16'h16BC, 16'h278D, 16'h349E
   };

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   chacha_round_sequencer_if bus ();
   chacha_round_sequencer_if bus4 ();

   chacha_round_sequencer #(.DOUBLE_ROUNDS(DR)) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   chacha_round_sequencer #(.DOUBLE_ROUNDS(DR4)) u_dut4 (
      .clk (clk),
      .rst (rst),
      .bus (bus4)
   );

   int total, bad, cyc;

   // scoreboard / model state for the ChaCha20 instance
   logic [15:0] exp_qr[$];
   logic [3:0]  exp_add[$];
   bit          active, stall_en, acc_prev;
   int          t0, done_cyc, qr_k, run_acc, done_cnt, stall_left;

   // counters for the ChaCha8 instance
   bit          acc4_prev;
   int          t4, acc4_cnt, add4_cnt, done4_cnt, done4_cyc;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      total++;
      assert (obs === expv) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   // Per-cycle work at the falling edge: compare outputs, act as the QR unit,
   // and update the model for the start/abort just sampled.
   task automatic monitor();
      bit acc;
      acc = 1'b0;
      if (rst) begin
         active    = 1'b0;
         acc_prev  = 1'b0;
         acc4_prev = 1'b0;
         exp_qr.delete();
         exp_add.delete();
         bus.qr_done   = 1'b0;
         bus.qr_ready  = 1'b1;
         bus4.qr_done  = 1'b0;
         bus4.qr_ready = 1'b1;
      end else begin
         check("busy", bus.busy, 32'(active && (cyc > t0) && (cyc <= done_cyc)));
         check("done", bus.done, 32'(active && (cyc == done_cyc)));
         if (bus.done) begin
            done_cnt++;
            check("dr_cnt_at_done", bus.dr_cnt, DR);
            check("qr_left_at_done", exp_qr.size(), 0);
            check("add_left_at_done", exp_add.size(), 0);
            check("qr_accepts", run_acc, 8 * DR);
         end
         if (bus.add_valid) begin
            check("add_q_nonempty", 32'(exp_add.size() > 0), 1);
            if (exp_add.size() > 0) check("add_idx", bus.add_idx, exp_add.pop_front());
            check("qr_valid_in_add", bus.qr_valid, 0);
         end
         if (bus.qr_valid) begin
            check("qr_q_nonempty", 32'(exp_qr.size() > 0), 1);
            if (exp_qr.size() > 0) begin
               check("qr_idx", {bus.qr_a, bus.qr_b, bus.qr_c, bus.qr_d}, exp_qr[0]);
               check("dr_cnt_at_req", bus.dr_cnt, qr_k / 8);
            end
            if ((stall_left > 0) && (qr_k == 5)) begin
               bus.qr_ready = 1'b0;
               stall_left--;
               done_cyc++;
            end else begin
               bus.qr_ready = 1'b1;
               acc = 1'b1;
               if (exp_qr.size() > 0) void'(exp_qr.pop_front());
               qr_k++;
               run_acc++;
            end
         end else begin
            bus.qr_ready = 1'b1;
         end
         bus.qr_done = acc_prev;
         acc_prev    = acc;

         if (bus.done) active = 1'b0;
         if (bus.abort && bus.busy) begin
            active = 1'b0;
            exp_qr.delete();
            exp_add.delete();
         end else if (bus.start && !bus.busy && !bus.abort) begin
            active     = 1'b1;
            t0         = cyc;
            done_cyc   = cyc + 16 * DR + 17;
            qr_k       = 0;
            run_acc    = 0;
            stall_left = stall_en ? 3 : 0;
            exp_qr.delete();
            exp_add.delete();
            for (int r = 0; r < DR; r++)
               for (int s = 0; s < 8; s++) exp_qr.push_back(SCHED[s]);
            for (int i = 0; i < 16; i++) exp_add.push_back(4'(i));
         end

         // ChaCha8 instance: qr_ready tied high, qr_done one cycle after accept
         if (bus4.done) begin
            done4_cnt++;
            done4_cyc = cyc;
         end
         bus4.qr_ready = 1'b1;
         bus4.qr_done  = acc4_prev;
         acc4_prev     = bus4.qr_valid && bus4.qr_ready;
         if (acc4_prev) acc4_cnt++;
         if (bus4.add_valid) add4_cnt++;
         if (bus4.start && !bus4.busy && !bus4.abort) begin
            t4       = cyc;
            acc4_cnt = 0;
            add4_cnt = 0;
         end
      end
   endtask

   task automatic tick();
      @(negedge clk);
      monitor();
      cyc++;
      @(posedge clk);
      #1;
   endtask

   function automatic bit cond(input int kind);
      case (kind)
         0:       return bus.qr_valid;
         1:       return bus.busy && !bus.qr_valid && !bus.add_valid && !bus.done;
         2:       return bus.add_valid;
         3:       return bus.done;
         4:       return bus.add_valid && (bus.add_idx == 4'd7);
         5:       return (run_acc == 41) && bus.busy && !bus.qr_valid;
         6:       return bus4.done;
         default: return 1'b0;
      endcase
   endfunction

   task automatic wait_for(input int kind, input int budget, input string tag);
      int n;
      n = 0;
      while (!cond(kind) && (n < budget)) begin
         tick();
         n++;
      end
      check(tag, 32'(cond(kind)), 1);
   endtask

   task automatic pulse_start();
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
   endtask

   task automatic check_outputs_zero(input string tag);
      check({tag, "_busy"}, bus.busy, 0);
      check({tag, "_done"}, bus.done, 0);
      check({tag, "_qr_valid"}, bus.qr_valid, 0);
      check({tag, "_qr_idx"}, {bus.qr_a, bus.qr_b, bus.qr_c, bus.qr_d}, 0);
      check({tag, "_add_valid"}, bus.add_valid, 0);
      check({tag, "_add_idx"}, bus.add_idx, 0);
      check({tag, "_dr_cnt"}, bus.dr_cnt, 0);
   endtask

   initial begin
      int n0;
      total = 0; bad = 0; cyc = 0;
      active = 1'b0; stall_en = 1'b0; acc_prev = 1'b0; acc4_prev = 1'b0;
      t0 = 0; done_cyc = 0; qr_k = 0; run_acc = 0; done_cnt = 0; stall_left = 0;
      t4 = 0; acc4_cnt = 0; add4_cnt = 0; done4_cnt = 0; done4_cyc = 0;
      rst = 1'b1;
      bus.start = 1'b0;  bus.abort = 1'b0;
      bus4.start = 1'b0; bus4.abort = 1'b0;
      repeat (2) tick();
      check_outputs_zero("reset");
      rst = 1'b0;
      repeat (2) tick();

      // abort wins over start while idle
      bus.start = 1'b1;
      bus.abort = 1'b1;
      tick();
      bus.start = 1'b0;
      bus.abort = 1'b0;
      tick();
      check("abort_over_start", bus.busy, 0);

      // nominal ChaCha20 block
      n0 = done_cnt;
      pulse_start();
      wait_for(3, 400, "run1_done_seen");
      tick();
      check("run1_done_count", done_cnt, n0 + 1);
      tick();

      // qr_ready held low for 3 cycles on request index 5
      stall_en = 1'b1;
      n0 = done_cnt;
      pulse_start();
      wait_for(3, 400, "stall_done_seen");
      tick();
      stall_en = 1'b0;
      check("stall_done_count", done_cnt, n0 + 1);
      tick();

      // start pulses in ISSUE, WAIT, ADD and DONE are ignored
      n0 = done_cnt;
      pulse_start();
      wait_for(0, 10, "ign_issue_seen");
      pulse_start();
      wait_for(1, 10, "ign_wait_seen");
      pulse_start();
      wait_for(2, 400, "ign_add_seen");
      pulse_start();
      wait_for(3, 40, "ign_done_seen");
      pulse_start();
      repeat (4) tick();
      check("ignored_start_done_count", done_cnt, n0 + 1);
      check("ignored_start_idle", bus.busy, 0);

      // abort during the WAIT of QR 40, then a full fresh block
      n0 = done_cnt;
      pulse_start();
      wait_for(5, 200, "qr40_wait_seen");
      bus.abort = 1'b1;
      tick();
      bus.abort = 1'b0;
      check_outputs_zero("abort");
      repeat (3) tick();
      check("abort_no_done", done_cnt, n0);
      pulse_start();
      wait_for(3, 400, "post_abort_done_seen");
      tick();
      check("post_abort_done_count", done_cnt, n0 + 1);
      tick();

      // asynchronous reset in the middle of the feed-forward phase
      n0 = done_cnt;
      pulse_start();
      wait_for(4, 400, "add7_seen");
      #2;
      rst = 1'b1;
      #1;
      check_outputs_zero("async_rst");
      tick();
      rst = 1'b0;
      repeat (3) tick();
      check("async_rst_no_done", done_cnt, n0);

      // ChaCha8 build
      bus4.start = 1'b1;
      tick();
      bus4.start = 1'b0;
      wait_for(6, 200, "dr4_done_seen");
      tick();
      check("dr4_accepts", acc4_cnt, 32);
      check("dr4_adds", add4_cnt, 16);
      check("dr4_latency", done4_cyc - t4, 81);
      check("dr4_dr_cnt", bus4.dr_cnt, DR4);
      check("dr4_done_count", done4_cnt, 1);
      tick();
      check("dr4_idle", bus4.busy, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
